// File: rtl/wrapped_instrumented_adder_if.sv
// Logic-analyser and GPIO bundle between the management side and the adder wrapper.
// The wrapper takes the slave modport; management or a testbench takes the master.
interface wrapped_instrumented_adder_if;
  logic        active;
  logic [31:0] la1_data_in;
  logic [31:0] la1_oenb;
  logic [31:0] la2_data_in;
  logic [31:0] la2_oenb;
  logic [31:0] la3_data_in;
  logic [31:0] la3_oenb;
  logic [31:0] la1_data_out;
  logic [31:0] la2_data_out;
  logic [31:0] la3_data_out;
  logic [37:0] io_in;
  logic [37:0] io_out;
  logic [37:0] io_oeb;

  modport slave (
    input  active, la1_data_in, la1_oenb, la2_data_in, la2_oenb,
           la3_data_in, la3_oenb, io_in,
    output la1_data_out, la2_data_out, la3_data_out, io_out, io_oeb
  );

  modport master (
    output active, la1_data_in, la1_oenb, la2_data_in, la2_oenb,
           la3_data_in, la3_oenb, io_in,
    input  la1_data_out, la2_data_out, la3_data_out, io_out, io_oeb
  );
endinterface

// File: rtl/wrapped_instrumented_adder.sv
// Instrumented 32-bit adder wrapper with a sum->A ring path and toggle/cycle counters.
// Define OUTPUT_REG_EN to register sum/carry; otherwise they are combinational.
module wrapped_instrumented_adder #(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RST_MASK = 32'h4000_0000
) (
  input logic                          wb_clk_i,
  input logic                          wb_rst_i,
  wrapped_instrumented_adder_if.slave  bus
);

  logic [31:0] ctrl;
  logic        run, load_a, load_b, load_ext, load_ring, load_sbit, clr;

  logic [WIDTH-1:0] a_input_q, b_input_q;
  logic [WIDTH-1:0] ext_mask_q, ring_mask_q, sbit_mask_q;
  logic             fb_q;
  logic [31:0]      ring_cnt_q, cycle_cnt_q;

  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;
  logic [WIDTH-1:0] sum_out;
  logic             chain_out;
  logic             fb_d;

  // A control bit counts only when its LA lane is driven and the project is selected.
  assign ctrl      = bus.la1_data_in & ~bus.la1_oenb & {32{bus.active}};
  assign run       = ctrl[0];
  assign load_a    = ctrl[1];
  assign load_b    = ctrl[2];
  assign load_ext  = ctrl[3];
  assign load_ring = ctrl[4];
  assign load_sbit = ctrl[5];
  assign clr       = ctrl[6];

  // External source wins over the ring path where both masks are set.
  assign a_eff = (a_input_q & ~ext_mask_q & ~ring_mask_q)
               | ({WIDTH{bus.io_in[37]}} & ext_mask_q)
               | ({WIDTH{fb_q}} & ring_mask_q & ~ext_mask_q);

  assign {carry_d, sum_d} = {1'b0, a_eff} + {1'b0, b_input_q};

`ifdef OUTPUT_REG_EN
  logic [WIDTH-1:0] sum_q;
  logic             chain_out_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sum_q       <= '0;
      chain_out_q <= 1'b0;
    end else if (bus.active) begin
      sum_q       <= sum_d;
      chain_out_q <= carry_d;
    end
  end

  assign sum_out   = sum_q;
  assign chain_out = chain_out_q;
`else
  assign sum_out   = sum_d;
  assign chain_out = carry_d;
`endif

  // Feedback sees the sum exactly as presented on the outputs.
  assign fb_d = ~^(sum_out & sbit_mask_q);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      a_input_q   <= '0;
      b_input_q   <= '0;
      ext_mask_q  <= RST_MASK[WIDTH-1:0];
      ring_mask_q <= RST_MASK[WIDTH-1:0];
      sbit_mask_q <= '0;
      fb_q        <= 1'b0;
      ring_cnt_q  <= '0;
      cycle_cnt_q <= '0;
    end else begin
      if (load_a)    a_input_q   <= bus.la2_data_in[WIDTH-1:0];
      if (load_b)    b_input_q   <= bus.la3_data_in[WIDTH-1:0];
      if (load_ext)  ext_mask_q  <= bus.la2_data_in[WIDTH-1:0];
      if (load_ring) ring_mask_q <= bus.la3_data_in[WIDTH-1:0];
      if (load_sbit) sbit_mask_q <= bus.la2_data_in[WIDTH-1:0];
      if (clr) begin
        fb_q        <= 1'b0;
        ring_cnt_q  <= '0;
        cycle_cnt_q <= '0;
      end else if (run) begin
        fb_q        <= fb_d;
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
        if (fb_d != fb_q) ring_cnt_q <= ring_cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    bus.la1_data_out = '0;
    bus.la2_data_out = '0;
    bus.la3_data_out = '0;
    bus.io_out       = '0;
    bus.io_oeb       = '1;
    if (bus.active) begin
      bus.la1_data_out = {cycle_cnt_q[23:0], 6'b0, fb_q, chain_out};
      bus.la2_data_out = ring_cnt_q;
      bus.la3_data_out = sum_out[31:0];
      bus.io_out       = {4'b0, fb_q, chain_out, sum_out[31:0]};
      bus.io_oeb       = {4'b1111, 34'b0};
    end
  end

  logic unused_sigs;
  assign unused_sigs = ^{bus.la2_oenb, bus.la3_oenb, bus.io_in[36:0], ctrl[31:7]};

endmodule

// File: tb/tb_wrapped_instrumented_adder.sv
// Directed-vector bench for wrapped_instrumented_adder; expectations are hand-computed.
module tb_wrapped_instrumented_adder;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  wrapped_instrumented_adder_if bus ();

  wrapped_instrumented_adder dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-output builds present the sum one edge later.
  task automatic settle();
`ifdef OUTPUT_REG_EN
    @(posedge clk); #1;
`else
    #1;
`endif
  endtask

  task automatic ctrl_pulse(input logic [31:0] word, input logic [31:0] a2, input logic [31:0] a3);
    @(negedge clk);
    bus.la2_data_in = a2;
    bus.la3_data_in = a3;
    bus.la1_data_in = word;
    @(posedge clk); #1;
    bus.la1_data_in = '0;
  endtask

  task automatic run_cycles(input int n, input logic [31:0] extra);
    @(negedge clk);
    bus.la1_data_in = 32'h1 | extra;
    repeat (n) @(posedge clk);
    #1;
    bus.la1_data_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.active = 1'b0;
    #1;
    checks++;
    if (bus.io_oeb !== 38'h3F_FFFF_FFFF) begin
      errors++; $display("FAIL reset_oeb_inactive: got %h want %h", bus.io_oeb, 38'h3F_FFFF_FFFF);
    end
    checks++;
    if ({bus.la1_data_out, bus.la2_data_out, bus.la3_data_out} !== 96'h0) begin
      errors++; $display("FAIL reset_la_inactive: got %h want 0", {bus.la1_data_out, bus.la2_data_out, bus.la3_data_out});
    end
    @(negedge clk);
    rst = 1'b0;
    bus.active = 1'b1;
    bus.io_in = 38'h20_0000_0000;
    settle();
    checks++;
    if (bus.la3_data_out !== 32'h4000_0000) begin
      errors++; $display("FAIL reset_ext_mask: got %h want %h", bus.la3_data_out, 32'h4000_0000);
    end
    checks++;
    if (bus.la2_data_out !== 32'h0 || bus.la1_data_out !== 32'h0) begin
      errors++; $display("FAIL reset_counters: la1 %h la2 %h want 0", bus.la1_data_out, bus.la2_data_out);
    end
    checks++;
    if (bus.io_oeb !== 38'h3C_0000_0000) begin
      errors++; $display("FAIL reset_oeb_active: got %h want %h", bus.io_oeb, 38'h3C_0000_0000);
    end
    bus.io_in = '0;
    settle();
    checks++;
    if (bus.la3_data_out !== 32'h0) begin
      errors++; $display("FAIL reset_ring_mask: got %h want 0", bus.la3_data_out);
    end
  endtask

  task automatic test_add();
    ctrl_pulse(32'h18, 32'h0, 32'h0);
    ctrl_pulse(32'h06, 32'hFFFF_FFFF, 32'h1);
    settle();
    checks++;
    if (bus.la3_data_out !== 32'h0) begin
      errors++; $display("FAIL add_wrap_sum: got %h want 0", bus.la3_data_out);
    end
    checks++;
    if (bus.io_out !== 38'h01_0000_0000) begin
      errors++; $display("FAIL add_io_out: got %h want %h", bus.io_out, 38'h01_0000_0000);
    end
    checks++;
    if (bus.la1_data_out !== 32'h1) begin
      errors++; $display("FAIL add_chain_out: got %h want 1", bus.la1_data_out);
    end
    ctrl_pulse(32'h06, 32'h1234_5678, 32'h1111_1111);
    settle();
    checks++;
    if (bus.la3_data_out !== 32'h2345_6789 || bus.io_out[32] !== 1'b0) begin
      errors++; $display("FAIL add_plain: got %h c%b want 23456789 c0", bus.la3_data_out, bus.io_out[32]);
    end
  endtask

  task automatic test_gating();
    ctrl_pulse(32'h06, 32'hFFFF_FFFF, 32'h1);
    bus.la1_oenb = '1;
    ctrl_pulse(32'h06, 32'h5, 32'h7);
    settle();
    checks++;
    if (bus.la3_data_out !== 32'h0) begin
      errors++; $display("FAIL gate_oenb_all: got %h want 0", bus.la3_data_out);
    end
    bus.la1_oenb = 32'h4;
    ctrl_pulse(32'h06, 32'h5, 32'h7);
    bus.la1_oenb = '0;
    settle();
    checks++;
    if (bus.la3_data_out !== 32'h6) begin
      errors++; $display("FAIL gate_oenb_bit: got %h want 6", bus.la3_data_out);
    end
  endtask

  task automatic test_ext();
    ctrl_pulse(32'h06, 32'h0, 32'h0);
    ctrl_pulse(32'h08, 32'h20, 32'h0);
    bus.io_in = 38'h20_0000_0000;
    settle();
    checks++;
    if (bus.la3_data_out !== 32'h20) begin
      errors++; $display("FAIL ext_high: got %h want 20", bus.la3_data_out);
    end
    bus.io_in = '0;
    settle();
    checks++;
    if (bus.la3_data_out !== 32'h0) begin
      errors++; $display("FAIL ext_low: got %h want 0", bus.la3_data_out);
    end
  endtask

  task automatic test_ring();
    ctrl_pulse(32'h0E, 32'h0, 32'h0);
    ctrl_pulse(32'h30, 32'h1, 32'h1);
    ctrl_pulse(32'h40, 32'h0, 32'h0);
    run_cycles(10, 32'h0);
    checks++;
    if (bus.la1_data_out[31:8] !== 24'd10) begin
      errors++; $display("FAIL ring_cycle_cnt: got %0d want 10", bus.la1_data_out[31:8]);
    end
`ifdef OUTPUT_REG_EN
    checks++;
    if (bus.la2_data_out == 32'h0) begin
      errors++; $display("FAIL ring_cnt_nonzero: got %0d want >0", bus.la2_data_out);
    end
`else
    checks++;
    if (bus.la2_data_out !== 32'd10) begin
      errors++; $display("FAIL ring_cnt: got %0d want 10", bus.la2_data_out);
    end
    checks++;
    if (bus.la1_data_out !== 32'h0000_0A00) begin
      errors++; $display("FAIL ring_status: got %h want 00000a00", bus.la1_data_out);
    end
`endif
  endtask

  task automatic test_clr_during_run();
    run_cycles(1, 32'h40);
    checks++;
    if (bus.la2_data_out !== 32'h0 || bus.la1_data_out[31:1] !== 31'h0) begin
      errors++; $display("FAIL clr_run: la1 %h la2 %h want 0", bus.la1_data_out, bus.la2_data_out);
    end
    run_cycles(3, 32'h0);
    checks++;
    if (bus.la1_data_out[31:8] !== 24'd3) begin
      errors++; $display("FAIL clr_recount: got %0d want 3", bus.la1_data_out[31:8]);
    end
`ifndef OUTPUT_REG_EN
    checks++;
    if (bus.la2_data_out !== 32'd3 || bus.la1_data_out !== 32'h0000_0302) begin
      errors++; $display("FAIL clr_recount_ring: la1 %h la2 %0d want 00000302 3", bus.la1_data_out, bus.la2_data_out);
    end
`endif
  endtask

  task automatic test_inactive_freeze();
    logic [31:0] la1_snap, la2_snap, la3_snap;
    la1_snap = bus.la1_data_out;
    la2_snap = bus.la2_data_out;
    la3_snap = bus.la3_data_out;
    @(negedge clk);
    bus.active = 1'b0;
    bus.la2_data_in = 32'h55;
    bus.la3_data_in = 32'h77;
    #1;
    checks++;
    if ({bus.la1_data_out, bus.la2_data_out, bus.la3_data_out} !== 96'h0 || bus.io_out !== 38'h0
        || bus.io_oeb !== 38'h3F_FFFF_FFFF) begin
      errors++; $display("FAIL inactive_outputs: la %h io %h oeb %h want 0 0 3fffffffff",
                         {bus.la1_data_out, bus.la2_data_out, bus.la3_data_out}, bus.io_out, bus.io_oeb);
    end
    run_cycles(5, 32'h46);
    bus.active = 1'b1;
    #1;
    checks++;
    if (bus.la1_data_out !== la1_snap || bus.la2_data_out !== la2_snap || bus.la3_data_out !== la3_snap) begin
      errors++; $display("FAIL inactive_frozen: la1 %h la2 %h la3 %h want %h %h %h", bus.la1_data_out,
                         bus.la2_data_out, bus.la3_data_out, la1_snap, la2_snap, la3_snap);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    bus.la1_data_in = 32'h1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.la2_data_out !== 32'h0 || bus.la1_data_out !== 32'h0 || bus.la3_data_out !== 32'h0) begin
      errors++; $display("FAIL reset_mid_run: la1 %h la2 %h la3 %h want 0", bus.la1_data_out,
                         bus.la2_data_out, bus.la3_data_out);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.la1_data_out !== 32'h0) begin
      errors++; $display("FAIL reset_holds_run: got %h want 0", bus.la1_data_out);
    end
    @(negedge clk);
    bus.la1_data_in = '0;
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.active      = 1'b0;
    bus.la1_data_in = '0;
    bus.la1_oenb    = '0;
    bus.la2_data_in = '0;
    bus.la2_oenb    = '1;
    bus.la3_data_in = '0;
    bus.la3_oenb    = '1;
    bus.io_in       = '0;
    test_reset();
    test_add();
    test_gating();
    test_ext();
    test_ring();
    test_clr_during_run();
    test_inactive_freeze();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
